interconn_tx: RTL

- Per-MVU transmit engine feeding one source port of the MVU crossbar interconnect.
- Accepts a block-transfer command: destination MVU mask, local source address, remote destination address and length.
- Reads words from local MVU memory, which has a fixed read latency, and streams them onto the crossbar send_* signals at one word per cycle.
- One transmitter per MVU; its send_* outputs drive that MVU's slice of the interconnect send buses.

---
 rtl/interconn_pkg.sv | 16 +
 rtl/interconn_tx_if.sv | 42 ++++
 rtl/interconn_tx_rdpipe.sv | 38 +++
 rtl/interconn_tx.sv | 118 +++++++++++
 4 files changed

// File: rtl/interconn_pkg.sv
// Shared definitions for the MVU crossbar interconnect and its per-MVU transmitters.
package interconn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_e;

    localparam int N_DEF     = 8;
    localparam int W_DEF     = 64;
    localparam int BADDR_DEF = 15;
    localparam int BLEN_DEF  = 15;
    localparam int RDLAT_DEF = 2;

endpackage

// File: rtl/interconn_tx_if.sv
// Command, local-memory read and crossbar send signals of one MVU transmitter.
interface interconn_tx_if #(
    parameter int N     = interconn_pkg::N_DEF,
    parameter int W     = interconn_pkg::W_DEF,
    parameter int BADDR = interconn_pkg::BADDR_DEF,
    parameter int BLEN  = interconn_pkg::BLEN_DEF
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [N-1:0]     cmd_dest;
    logic [BADDR-1:0] cmd_src_addr;
    logic [BADDR-1:0] cmd_dst_addr;
    logic [BLEN-1:0]  cmd_len;

    logic             mem_rd_en;
    logic [BADDR-1:0] mem_rd_addr;
    logic [W-1:0]     mem_rd_word;

    logic [N-1:0]     send_to;
    logic             send_en;
    logic [BADDR-1:0] send_addr;
    logic [W-1:0]     send_word;

    logic             busy;
    logic             done;

    // The transmitter engine side.
    modport master (
        input  cmd_valid, cmd_dest, cmd_src_addr, cmd_dst_addr, cmd_len, mem_rd_word,
        output cmd_ready, mem_rd_en, mem_rd_addr,
        output send_to, send_en, send_addr, send_word, busy, done
    );

    // The command issuer / memory / crossbar side.
    modport slave (
        output cmd_valid, cmd_dest, cmd_src_addr, cmd_dst_addr, cmd_len, mem_rd_word,
        input  cmd_ready, mem_rd_en, mem_rd_addr,
        input  send_to, send_en, send_addr, send_word, busy, done
    );

endinterface

// File: rtl/interconn_tx_rdpipe.sv
// Delay line carrying {valid, remote address} alongside each outstanding local read.
module interconn_tx_rdpipe #(
    parameter int RDLAT = 2,
    parameter int BADDR = 15
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_vld,
    input  logic [BADDR-1:0] in_addr,
    output logic             tail_vld,
    output logic [BADDR-1:0] tail_addr,
    output logic             any_vld
);

    logic [RDLAT-1:0] vld_p;
    logic [BADDR-1:0] addr_p [RDLAT];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vld_p <= '0;
            for (int i = 0; i < RDLAT; i++) begin
                addr_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= in_vld;
            addr_p[0] <= in_addr;
            for (int i = 1; i < RDLAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    assign tail_vld  = vld_p[RDLAT-1];
    assign tail_addr = addr_p[RDLAT-1];
    assign any_vld   = |vld_p;

endmodule

// File: rtl/interconn_tx.sv
// Per-MVU transmit engine: reads a block from local memory and streams it onto
// this MVU's slice of the crossbar send buses, one word per cycle.
module interconn_tx
    import interconn_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int BADDR = BADDR_DEF,
    parameter int BLEN  = BLEN_DEF,
    parameter int RDLAT = RDLAT_DEF
) (
    input  logic           clk,
    input  logic           clr_n,
    interconn_tx_if.master tx
);

    tx_state_e        state;
    logic [N-1:0]     dest_q;
    logic [BADDR-1:0] dst_cur;
    logic [BLEN-1:0]  remain;

    logic             tail_vld;
    logic [BADDR-1:0] tail_addr;
    logic             pipe_any;

    // Command / read-issue stage
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state          <= IDLE;
            tx.cmd_ready   <= 1'b1;
            tx.busy        <= 1'b0;
            tx.done        <= 1'b0;
            tx.mem_rd_en   <= 1'b0;
            tx.mem_rd_addr <= '0;
            dest_q         <= '0;
            dst_cur        <= '0;
            remain         <= '0;
        end else begin
            tx.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx.cmd_valid && tx.cmd_ready) begin
                        dest_q <= tx.cmd_dest;
                        if (tx.cmd_len != '0) begin
                            state          <= RUN;
                            tx.cmd_ready   <= 1'b0;
                            tx.busy        <= 1'b1;
                            tx.mem_rd_en   <= 1'b1;
                            tx.mem_rd_addr <= tx.cmd_src_addr;
                            dst_cur        <= tx.cmd_dst_addr;
                            remain         <= tx.cmd_len;
                        end else begin
                            tx.done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // remain counts the read being issued this cycle
                    if (remain == BLEN'(1)) begin
                        state          <= DRAIN;
                        tx.mem_rd_en   <= 1'b0;
                        tx.mem_rd_addr <= '0;
                    end else begin
                        remain         <= remain - BLEN'(1);
                        tx.mem_rd_addr <= tx.mem_rd_addr + BADDR'(1);
                        dst_cur        <= dst_cur + BADDR'(1);
                    end
                end
                DRAIN: begin
                    // Pipe empty here means the last word is on the send stage now.
                    if (!pipe_any) begin
                        state        <= IDLE;
                        tx.done      <= 1'b1;
                        tx.busy      <= 1'b0;
                        tx.cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    interconn_tx_rdpipe #(
        .RDLAT (RDLAT),
        .BADDR (BADDR)
    ) u_rdpipe (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_vld    (tx.mem_rd_en),
        .in_addr   (dst_cur),
        .tail_vld  (tail_vld),
        .tail_addr (tail_addr),
        .any_vld   (pipe_any)
    );

    // Send stage: idle buses are zero so the crossbar can OR-reduce them.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tx.send_en   <= 1'b0;
            tx.send_to   <= '0;
            tx.send_addr <= '0;
            tx.send_word <= '0;
        end else if (tail_vld) begin
            tx.send_en   <= 1'b1;
            tx.send_to   <= dest_q;
            tx.send_addr <= tail_addr;
            tx.send_word <= tx.mem_rd_word;
        end else begin
            tx.send_en   <= 1'b0;
            tx.send_to   <= '0;
            tx.send_addr <= '0;
            tx.send_word <= '0;
        end
    end

endmodule
